peppe: RTL and testbench

PEPPE -- requirements
Module: peppe

---
 rtl/peppe.sv | 31 +++
 tb/tb_peppe.sv | 90 +++++++++
 2 files changed

// File: rtl/peppe.sv
// peppe: registered field select with equality flag between two selected fields
module peppe #(
  parameter int FIELD_W = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [4*FIELD_W-1:0] X,
  input  logic [1:0]           SEL1,
  input  logic [1:0]           SEL2,
  output logic [FIELD_W-1:0]   Y,
  output logic                 E
);
  logic [FIELD_W-1:0] f [4];
  logic [FIELD_W-1:0] a, b;
  for (genvar i = 0; i < 4; i++) begin : g_field
    assign f[i] = X[i*FIELD_W +: FIELD_W];
  end
  always_comb begin
    a = f[SEL1];
    b = f[SEL2];
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      Y <= '0;
      E <= 1'b0;
    end else begin
      Y <= a;
      E <= (a == b);
    end
  end
endmodule

// File: tb/tb_peppe.sv
// tb_peppe: directed scoreboard bench for peppe
module tb_peppe;
  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] X;
  logic [1:0] SEL1, SEL2;
  logic [1:0] Y;
  logic       E;
  logic [2:0] sb [$];
  logic [2:0] last;
  int         n_vec = 0;
  int         n_err = 0;

  peppe dut (.clk(clk), .rst(rst), .X(X), .SEL1(SEL1), .SEL2(SEL2), .Y(Y), .E(E));

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  function automatic logic [2:0] model(logic r, logic [7:0] x, logic [1:0] s1, logic [1:0] s2);
    logic [1:0] p, q;
    if (r) return 3'b000;
    p = 2'((x >> (2 * s1)) & 8'h03);
    q = 2'((x >> (2 * s2)) & 8'h03);
    return {p, p == q};
  endfunction

  task automatic chk(string tag, logic [2:0] got, logic [2:0] exp);
    n_vec++;
    assert (got === exp) else begin
      n_err++;
      $error("FAIL %s got Y/E=%b required=%b", tag, got, exp);
    end
  endtask

  task automatic apply(string tag, logic r, logic [7:0] x, logic [1:0] s1, logic [1:0] s2);
    rst = r; X = x; SEL1 = s1; SEL2 = s2;
    sb.push_back(model(r, x, s1, s2));
    @(posedge clk);
    #1;
    if (sb.size() == 0) begin
      n_vec++; n_err++;
      $display("FAIL %s got=empty_scoreboard required=entry", tag);
    end else begin
      last = sb.pop_front();
      chk(tag, {Y, E}, last);
    end
  endtask

  task automatic hold(string tag);
    X = ~X; SEL1 = SEL1 + 2'd1; SEL2 = SEL2 + 2'd2;
    #3;
    chk(tag, {Y, E}, last);
  endtask

  initial begin
    apply("rst0", 1'b1, 8'hFF, 2'd0, 2'd0);
    apply("rst1", 1'b1, 8'hFF, 2'd0, 2'd0);
    apply("sel3_0", 1'b0, 8'b10_11_00_01, 2'd3, 2'd0);
    hold("hold_a");
    apply("sel0_0", 1'b0, 8'b10_11_00_01, 2'd0, 2'd0);
    apply("sel1_0", 1'b0, 8'b10_10_00_01, 2'd1, 2'd0);
    apply("sel2_1", 1'b0, 8'b10_10_00_01, 2'd2, 2'd1);
    hold("hold_b");
    apply("sel3_2", 1'b0, 8'b10_10_00_11, 2'd3, 2'd2);
    apply("zero3_3", 1'b0, 8'h00, 2'd3, 2'd3);
    apply("sel0_3", 1'b0, 8'b01_00_11_01, 2'd0, 2'd3);
    apply("sel2_0", 1'b0, 8'b01_10_11_10, 2'd2, 2'd0);
    for (int i = 0; i < 8; i++) begin
      apply("stream", 1'b0, 8'($urandom), 2'($urandom), 2'($urandom));
    end
    apply("midrst", 1'b1, 8'b11_11_11_11, 2'd3, 2'd3);
    hold("hold_rst");
    apply("resume", 1'b0, 8'b11_01_10_00, 2'd2, 2'd2);
    apply("resume2", 1'b0, 8'b11_01_10_00, 2'd3, 2'd1);
    for (int i = 0; i < 16; i++) begin
      apply("rand", 1'b0, 8'($urandom), 2'($urandom), 2'($urandom));
      if (i % 4 == 1) hold("hold_r");
    end
    for (int s = 0; s < 4; s++) begin
      apply("same_sel", 1'b0, 8'($urandom), 2'(s), 2'(s));
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
